// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver FSM states.
package uart_pkg;
  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry output register with valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [CW-1:0]        cyc, cyc_n;
  logic [2:0]           bit_cnt, bit_n;
  logic                 bits_done, bits_done_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 byte_done, byte_done_n;
  logic                 ferr_n;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_pin),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      bit_cnt   <= '0;
      bits_done <= 1'b0;
      shift     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      bit_cnt   <= bit_n;
      bits_done <= bits_done_n;
      shift     <= shift_n;
      byte_done <= byte_done_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    bit_n       = bit_cnt;
    bits_done_n = bits_done;
    shift_n     = shift;
    byte_done_n = 1'b0;
    ferr_n      = 1'b0;
    case (state)
      IDLE: begin
        cyc_n       = '0;
        bit_n       = '0;
        bits_done_n = 1'b0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cyc == HALF_M1) begin
          cyc_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      DATA: begin
        if (cyc == FULL_M1) begin
          cyc_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          // Hold the bit counter at 7 on the last bit so it never wraps inside a frame.
          if (bit_cnt == 3'd7) begin
            bits_done_n = 1'b1;
            state_n     = STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      STOP: begin
        if (cyc == FULL_M1 && bits_done) begin
          cyc_n = '0;
          if (rx_s) begin
            byte_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      BREAK: begin
        cyc_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output register: a simultaneous accept frees the slot for the byte completing this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!data_valid || data_ready) begin
          data       <= shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks/bit: table of frames plus handshake, glitch, break and reset sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_pin     (rx_pin),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_loads = 0, n_ferr = 0, n_ovr = 0, n_dv_cyc = 0, n_dv_fall = 0;
  logic [7:0] exp_q[$];
  logic prev_dv = 1'b0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Scoreboard monitor: a load is valid rising, or valid held across an accept edge.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(posedge clk);
      #2;
      if (data_valid) n_dv_cyc++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (prev_dv && !data_valid) n_dv_fall++;
      if (data_valid && (!prev_dv || data_ready)) begin
        n_loads++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got 0x%0h, expected no byte at %0t", data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("sb_data", int'(data), int'(exp_b));
        end
      end
      prev_dv = data_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge; drives one full 8N1 frame with the given stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(CPB);
    end
    rx_pin = stop;
    idle(CPB);
    rx_pin = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_load;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int l0, f0, o0, d0, fa0;

    tbl[0] = '{8'h54, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1, 0};
    tbl[3] = '{8'hA5, 1'b1, 1, 0};
    tbl[4] = '{8'h80, 1'b1, 1, 0};
    tbl[5] = '{8'hC3, 1'b0, 0, 1};
    tbl[6] = '{8'h01, 1'b1, 1, 0};

    idle(3);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    check("rst_sync", int'(dut.rx_s), 1);
    reset = 1'b0;
    idle(10);

    data_ready = 1'b1;
    foreach (tbl[k]) begin
      l0 = n_loads; f0 = n_ferr; d0 = n_dv_cyc; o0 = n_ovr;
      if (tbl[k].exp_load != 0) exp_q.push_back(tbl[k].b);
      send_byte(tbl[k].b, tbl[k].stop);
      idle(20);
      check("tbl_loads", n_loads - l0, tbl[k].exp_load);
      check("tbl_ferr", n_ferr - f0, tbl[k].exp_ferr);
      check("tbl_dv_cycles", n_dv_cyc - d0, tbl[k].exp_load);
      check("tbl_ovr", n_ovr - o0, 0);
    end

    // Back-to-back with no consumer: second byte overruns, first is retained.
    data_ready = 1'b0;
    l0 = n_loads; o0 = n_ovr;
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    send_byte(8'h0A, 1'b1);
    idle(20);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_loads", n_loads - l0, 1);
    check("ovr_valid", int'(data_valid), 1);
    check("ovr_data", int'(data), 8'h41);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
    idle(2);
    check("acc_valid", int'(data_valid), 0);
    check("acc_data", int'(data), 8'h41);

    // Accept exactly on the load edge of the second byte: start edge + 2 sync + 1 + 152 + 1.
    l0 = n_loads; o0 = n_ovr; fa0 = n_dv_fall;
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    exp_q.push_back(8'h0A);
    fork
      send_byte(8'h0A, 1'b1);
      begin
        idle(155);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
      end
    join
    idle(20);
    check("repl_ovr", n_ovr - o0, 0);
    check("repl_fall", n_dv_fall - fa0, 0);
    check("repl_loads", n_loads - l0, 2);
    check("repl_valid", int'(data_valid), 1);
    check("repl_data", int'(data), 8'h0A);
    data_ready = 1'b1;
    idle(3);
    check("repl_drain", int'(data_valid), 0);

    // Short low glitch.
    l0 = n_loads; f0 = n_ferr;
    rx_pin = 1'b0;
    idle(4);
    rx_pin = 1'b1;
    idle(40);
    check("glitch_loads", n_loads - l0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_state", int'(dut.state), int'(IDLE));

    // Framing error followed by a long break, then a good byte.
    l0 = n_loads; f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    rx_pin = 1'b0;
    idle(100);
    rx_pin = 1'b1;
    idle(5);
    check("brk_ferr", n_ferr - f0, 1);
    check("brk_loads", n_loads - l0, 0);
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b1);
    idle(20);
    check("brk_next_loads", n_loads - l0, 1);
    check("brk_next_ferr", n_ferr - f0, 1);
    check("brk_next_data", int'(data), 8'h33);

    // Reset during data bit 4 of 0xFF drops the frame and the pending byte.
    data_ready = 1'b0;
    l0 = n_loads; f0 = n_ferr;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    idle(5);
    check("pend_valid", int'(data_valid), 1);
    rx_pin = 1'b0;
    idle(CPB);
    rx_pin = 1'b1;
    idle(4 * CPB + CPB / 2);
    reset = 1'b1;
    idle(3);
    check("midrst_valid", int'(data_valid), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_state", int'(dut.state), int'(IDLE));
    reset = 1'b0;
    idle(4 * CPB);
    check("midrst_loads", n_loads - l0, 1);
    check("midrst_ferr", n_ferr - f0, 0);
    data_ready = 1'b1;
    exp_q.push_back(8'h0D);
    send_byte(8'h0D, 1'b1);
    idle(20);
    check("midrst_next_loads", n_loads - l0, 2);
    check("midrst_next_data", int'(data), 8'h0D);

    // Line already low when reset releases counts as a start edge.
    l0 = n_loads;
    reset = 1'b1;
    rx_pin = 1'b0;
    idle(3);
    reset = 1'b0;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check("lowrst_loads", n_loads - l0, 1);
    check("lowrst_data", int'(data), 8'h5A);

    idle(10);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
